// File: rtl/math_pkg.sv
// Fixed-point widths, solver FSM state type and the saturation helper shared by the
// 2x2 solver datapath.
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 16
`endif

package math_pkg;

   localparam int FX_W     = `FLOAT_BITS;
   localparam int FX_D     = `FLOAT_DCM_BITS;
   localparam int FX_P     = 2 * FX_W + 1;
   localparam int FX_NW    = FX_P + FX_D;
   localparam int SAT_IN_W = FX_NW + 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_DIV1 = 3'd2,
      ST_DIV2 = 3'd3,
      ST_DONE = 3'd4
   } solve_state_t;

   typedef struct packed {
      logic [FX_W-1:0] val;
      logic            ovf;
   } sat_t;

   // Clamp a wide signed quotient into FX_W bits; exactly -2^(W-1) passes unflagged.
   function automatic sat_t sat_to_w(input logic signed [SAT_IN_W-1:0] x);
      logic signed [SAT_IN_W-1:0] max_s;
      logic signed [SAT_IN_W-1:0] min_s;
      sat_t                       r_s;
      max_s = {{(SAT_IN_W-FX_W+1){1'b0}}, {(FX_W-1){1'b1}}};
      min_s = {{(SAT_IN_W-FX_W+1){1'b1}}, {(FX_W-1){1'b0}}};
      if (x > max_s) begin
         r_s.val = max_s[FX_W-1:0];
         r_s.ovf = 1'b1;
      end else if (x < min_s) begin
         r_s.val = min_s[FX_W-1:0];
         r_s.ovf = 1'b1;
      end else begin
         r_s.val = x[FX_W-1:0];
         r_s.ovf = 1'b0;
      end
      return r_s;
   endfunction

endpackage

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per cycle. The start cycle performs
// the first step, so done is visible exactly NDW cycles after start.
module seq_divider_u #(
   parameter int NDW = 81,
   parameter int DVW = 65
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [NDW-1:0] dividend,
   input  logic [DVW-1:0] divisor,
   output logic           done,
   output logic [NDW-1:0] quotient
);

   localparam int CW = $clog2(NDW + 1);

   logic [DVW-1:0] rem_r;
   logic [DVW-1:0] divisor_r;
   logic [NDW-1:0] quo_r;
   logic [CW-1:0]  cnt_r;
   logic           busy_r;
   logic           done_r;

   logic [DVW-1:0] rem_in_s;
   logic [DVW-1:0] div_in_s;
   logic [NDW-1:0] quo_in_s;
   logic [DVW:0]   shifted_s;
   logic [DVW:0]   diff_s;
   logic [DVW-1:0] rem_nx_s;
   logic [NDW-1:0] quo_nx_s;

   // Single shift/subtract step, fed from the fresh operands on the start cycle.
   always_comb begin
      if (start) begin
         rem_in_s = {DVW{1'b0}};
         quo_in_s = dividend;
         div_in_s = divisor;
      end else begin
         rem_in_s = rem_r;
         quo_in_s = quo_r;
         div_in_s = divisor_r;
      end
      shifted_s = {rem_in_s, quo_in_s[NDW-1]};
      diff_s    = shifted_s - {1'b0, div_in_s};
      if (shifted_s >= {1'b0, div_in_s}) begin
         rem_nx_s = diff_s[DVW-1:0];
         quo_nx_s = {quo_in_s[NDW-2:0], 1'b1};
      end else begin
         rem_nx_s = shifted_s[DVW-1:0];
         quo_nx_s = {quo_in_s[NDW-2:0], 1'b0};
      end
   end

   // Iteration state; reset discards any partial quotient.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_r     <= {DVW{1'b0}};
         divisor_r <= {DVW{1'b0}};
         quo_r     <= {NDW{1'b0}};
         cnt_r     <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else if (start) begin
         rem_r     <= rem_nx_s;
         divisor_r <= divisor;
         quo_r     <= quo_nx_s;
         cnt_r     <= CW'(NDW - 1);
         busy_r    <= 1'b1;
         done_r    <= 1'b0;
      end else if (busy_r) begin
         rem_r <= rem_nx_s;
         quo_r <= quo_nx_s;
         cnt_r <= cnt_r - CW'(1);
         if (cnt_r == CW'(1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end
   end

   assign done     = done_r;
   assign quotient = quo_r;

endmodule

// File: rtl/matrix_solve_2x2.sv
// Solves (u1,u2) = (v1,v2)*inv(A) for a 2x2 signed fixed-point matrix using one shared
// sequential divider: u_i = (n_i <<< D) / det, truncating toward zero and saturating.
module matrix_solve_2x2 #(
   parameter int W = `FLOAT_BITS,
   parameter int D = `FLOAT_DCM_BITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] v1,
   input  logic [W-1:0] v2,
   input  logic [W-1:0] a11,
   input  logic [W-1:0] a12,
   input  logic [W-1:0] a21,
   input  logic [W-1:0] a22,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] u1,
   output logic [W-1:0] u2,
   output logic         singular,
   output logic         overflow
);

   import math_pkg::*;

   localparam int P  = 2 * W + 1;
   localparam int NW = P + D;

   solve_state_t         state_r;
   logic                 prep_phase_r;
   logic [W-1:0]         v1_r, v2_r, a11_r, a12_r, a21_r, a22_r;
   logic signed [P-1:0]  det_r, n1_r, n2_r;
   logic [W-1:0]         u1_r, u2_r;
   logic                 singular_r, overflow_r, out_valid_r, in_ready_r;

   logic signed [P-1:0]  ev1_s, ev2_s, e11_s, e12_s, e21_s, e22_s;
   logic signed [P-1:0]  det_s, n1_s, n2_s, n_sel_s;
   logic [P-1:0]         det_mag_s, n_mag_s;
   logic                 q_neg_s, div_start_s, div_done_s;
   logic [NW-1:0]        dividend_s, div_quo_s;
   logic signed [NW:0]   q_signed_s;
   sat_t                 sat_s;

   // Exact determinant and numerators; operands are sign-extended to P bits first.
   always_comb begin
      ev1_s = {{(P-W){v1_r[W-1]}}, v1_r};
      ev2_s = {{(P-W){v2_r[W-1]}}, v2_r};
      e11_s = {{(P-W){a11_r[W-1]}}, a11_r};
      e12_s = {{(P-W){a12_r[W-1]}}, a12_r};
      e21_s = {{(P-W){a21_r[W-1]}}, a21_r};
      e22_s = {{(P-W){a22_r[W-1]}}, a22_r};
      det_s = e11_s * e22_s - e12_s * e21_s;
      n1_s  = ev1_s * e22_s - ev2_s * e21_s;
      n2_s  = ev2_s * e11_s - ev1_s * e12_s;
   end

   // Magnitude division with sign fixup; PREP feeds n1, the DIV1 handoff feeds n2.
   always_comb begin
      div_start_s = 1'b0;
      n_sel_s     = n2_r;
      q_neg_s     = n2_r[P-1] ^ det_r[P-1];
      case (state_r)
         ST_PREP: begin
            n_sel_s     = n1_r;
            div_start_s = prep_phase_r && (det_r != {P{1'b0}});
         end
         ST_DIV1: begin
            q_neg_s     = n1_r[P-1] ^ det_r[P-1];
            div_start_s = div_done_s;
         end
         default: begin
            div_start_s = 1'b0;
         end
      endcase
      if (det_r[P-1]) begin
         det_mag_s = -det_r;
      end else begin
         det_mag_s = det_r;
      end
      if (n_sel_s[P-1]) begin
         n_mag_s = -n_sel_s;
      end else begin
         n_mag_s = n_sel_s;
      end
      dividend_s = {n_mag_s, {D{1'b0}}};
      if (q_neg_s) begin
         q_signed_s = -$signed({1'b0, div_quo_s});
      end else begin
         q_signed_s = $signed({1'b0, div_quo_s});
      end
      sat_s = sat_to_w(q_signed_s);
   end

   seq_divider_u #(
      .NDW(NW),
      .DVW(P)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (div_start_s),
      .dividend(dividend_s),
      .divisor (det_mag_s),
      .done    (div_done_s),
      .quotient(div_quo_s)
   );

   // Control FSM with all handshake and result outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         prep_phase_r <= 1'b0;
         v1_r         <= {W{1'b0}};
         v2_r         <= {W{1'b0}};
         a11_r        <= {W{1'b0}};
         a12_r        <= {W{1'b0}};
         a21_r        <= {W{1'b0}};
         a22_r        <= {W{1'b0}};
         det_r        <= {P{1'b0}};
         n1_r         <= {P{1'b0}};
         n2_r         <= {P{1'b0}};
         u1_r         <= {W{1'b0}};
         u2_r         <= {W{1'b0}};
         singular_r   <= 1'b0;
         overflow_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  v1_r         <= v1;
                  v2_r         <= v2;
                  a11_r        <= a11;
                  a12_r        <= a12;
                  a21_r        <= a21;
                  a22_r        <= a22;
                  in_ready_r   <= 1'b0;
                  prep_phase_r <= 1'b0;
                  state_r      <= ST_PREP;
               end
            end
            ST_PREP: begin
               if (!prep_phase_r) begin
                  det_r        <= det_s;
                  n1_r         <= n1_s;
                  n2_r         <= n2_s;
                  prep_phase_r <= 1'b1;
               end else if (det_r == {P{1'b0}}) begin
                  singular_r  <= 1'b1;
                  overflow_r  <= 1'b0;
                  u1_r        <= {W{1'b0}};
                  u2_r        <= {W{1'b0}};
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  singular_r <= 1'b0;
                  overflow_r <= 1'b0;
                  state_r    <= ST_DIV1;
               end
            end
            ST_DIV1: begin
               if (div_done_s) begin
                  u1_r       <= sat_s.val;
                  overflow_r <= sat_s.ovf;
                  state_r    <= ST_DIV2;
               end
            end
            ST_DIV2: begin
               if (div_done_s) begin
                  u2_r        <= sat_s.val;
                  overflow_r  <= overflow_r | sat_s.ovf;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign u1        = u1_r;
   assign u2        = u2_r;
   assign singular  = singular_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_matrix_solve_2x2.sv
// Directed, table-driven bench for matrix_solve_2x2 (W=32, D=16) plus hand-written
// backpressure and mid-division reset sequences.
module tb_matrix_solve_2x2;

   localparam int LAT_DIV  = 2 * 81 + 2;
   localparam int LAT_SING = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] v1, v2, a11, a12, a21, a22, u1, u2;
   logic        singular, overflow;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [31:0] v1, v2, a11, a12, a21, a22;
      logic [31:0] eu1, eu2;
      logic        esing, eovf;
      int          elat;
   } vec_t;

   vec_t vecs[8];

   matrix_solve_2x2 #(.W(32), .D(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .v1(v1), .v2(v2), .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .out_valid(out_valid), .out_ready(out_ready),
      .u1(u1), .u2(u2), .singular(singular), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [31:0] pv1, input logic [31:0] pv2,
                               input logic [31:0] p11, input logic [31:0] p12,
                               input logic [31:0] p21, input logic [31:0] p22,
                               input logic [31:0] eu1, input logic [31:0] eu2,
                               input logic esing, input logic eovf, input int elat);
      vec_t t;
      t.name = name; t.v1 = pv1; t.v2 = pv2;
      t.a11 = p11; t.a12 = p12; t.a21 = p21; t.a22 = p22;
      t.eu1 = eu1; t.eu2 = eu2; t.esing = esing; t.eovf = eovf; t.elat = elat;
      return t;
   endfunction

   // Present one operation, then scramble inputs and keep in_valid high while busy.
   task automatic issue(input vec_t t);
      @(negedge clk);
      check({t.name, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      v1 = t.v1; v2 = t.v2; a11 = t.a11; a12 = t.a12; a21 = t.a21; a22 = t.a22;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      v1 = $urandom; v2 = $urandom; a11 = $urandom; a12 = $urandom; a21 = $urandom; a22 = $urandom;
   endtask

   // Wait (bounded) for out_valid and check latency, in_ready and results.
   task automatic await_result(input vec_t t);
      int  lat;
      bit  ready_seen;
      lat = 0;
      ready_seen = 1'b0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (in_ready) ready_seen = 1'b1;
      end while (!out_valid && lat < 400);
      in_valid = 1'b0;
      check({t.name, ".latency"}, lat, t.elat);
      check({t.name, ".in_ready_busy"}, {31'd0, ready_seen}, 32'd0);
      check({t.name, ".u1"}, u1, t.eu1);
      check({t.name, ".u2"}, u2, t.eu2);
      check({t.name, ".singular"}, {31'd0, singular}, {31'd0, t.esing});
      check({t.name, ".overflow"}, {31'd0, overflow}, {31'd0, t.eovf});
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({name, ".in_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = mk("identity", 32'h00030000, 32'hFFFE0000, 32'h00010000, 32'h0, 32'h0, 32'h00010000,
                   32'h00030000, 32'hFFFE0000, 1'b0, 1'b0, LAT_DIV);
      vecs[1] = mk("rot90", 32'h00018000, 32'h00020000, 32'h0, 32'h00010000, 32'hFFFF0000, 32'h0,
                   32'h00020000, 32'hFFFE8000, 1'b0, 1'b0, LAT_DIV);
      vecs[2] = mk("scale", 32'h00010000, 32'h00010000, 32'h00020000, 32'h0, 32'h0, 32'h00008000,
                   32'h00008000, 32'h00020000, 1'b0, 1'b0, LAT_DIV);
      vecs[3] = mk("singular", 32'h00012345, 32'h00006789, 32'h00010000, 32'h00010000, 32'h00010000,
                   32'h00010000, 32'h0, 32'h0, 1'b1, 1'b0, LAT_SING);
      vecs[4] = mk("ovf_pos", 32'h00010000, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1,
                   32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, LAT_DIV);
      vecs[5] = mk("neg_min_exact", 32'hFFFF8000, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1,
                   32'h80000000, 32'h0, 1'b0, 1'b0, LAT_DIV);
      vecs[6] = mk("ovf_neg", 32'h0, 32'hFFFF7FFF, 32'h1, 32'h0, 32'h0, 32'h1,
                   32'h0, 32'h80000000, 1'b0, 1'b1, LAT_DIV);
      vecs[7] = mk("trunc_third", 32'h00010000, 32'hFFFF0000, 32'h00030000, 32'h0, 32'h0, 32'h00030000,
                   32'h00005555, 32'hFFFFAAAB, 1'b0, 1'b0, LAT_DIV);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      v1 = 32'h0; v2 = 32'h0; a11 = 32'h0; a12 = 32'h0; a21 = 32'h0; a22 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.out_valid", {31'd0, out_valid}, 32'd0);
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
      check("reset.u1", u1, 32'h0);
      check("reset.u2", u2, 32'h0);
      check("reset.singular", {31'd0, singular}, 32'd0);
      check("reset.overflow", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i]);
         await_result(vecs[i]);
         release_result(vecs[i].name);
      end

      // Reset in the middle of DIV1 must abandon the operation and clear results.
      issue(vecs[0]);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midreset.out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset.in_ready", {31'd0, in_ready}, 32'd1);
      check("midreset.u1", u1, 32'h0);
      check("midreset.u2", u2, 32'h0);
      issue(vecs[0]);
      await_result(vecs[0]);
      release_result("after_reset");

      // Backpressure: results and handshake must hold while out_ready stays low.
      issue(vecs[2]);
      await_result(vecs[2]);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("hold.u1", u1, vecs[2].eu1);
         check("hold.u2", u2, vecs[2].eu2);
         check("hold.flags", {30'd0, singular, overflow}, 32'd0);
         check("hold.out_valid", {31'd0, out_valid}, 32'd1);
         check("hold.in_ready", {31'd0, in_ready}, 32'd0);
      end
      release_result("hold");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/matrix_solve_2x2.md
Name: matrix_solve_2x2

Overview:
- Inverse of the 2x2 fixed-point row-vector × matrix transform. Given result vector (v1,v2) and matrix A, it recovers (u1,u2) = (v1,v2)·A⁻¹.
- Used to map screen/target coordinates back into piece-local coordinates, for hit-testing and placement of rotated tangram pieces.
- Sequential, valid/ready handshake, one shared iterative divider.

Parameters:
- W, default `FLOAT_BITS: width of every signed fixed-point operand and result.
- D, default `FLOAT_DCM_BITS: number of fractional bits (1.0 = 2^D).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- v1, v2  in  W  signed input vector
- a11, a12, a21, a22  in  W  signed matrix; forward relation is v1=u1·a11+u2·a21, v2=u1·a12+u2·a22
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- u1, u2  out  W  signed solved vector
- singular  out  1  det == 0; u1 = u2 = 0
- overflow  out  1  at least one result saturated

Behaviour:
- Width rules:
  - P = 2W+1 (full determinant/numerator width); NW = P+D (dividend width).
- Math, all exact products, no intermediate truncation:
  - det = a11·a22 − a12·a21
  - n1 = v1·a22 − v2·a21
  - n2 = v2·a11 − v1·a12
  - u_i = (n_i <<< D) / det
  - Signed division is done on magnitudes with sign fixup; the quotient truncates toward zero.
- Saturation: a quotient above 2^(W−1)−1 clamps to that value; one below −2^(W−1) clamps to −2^(W−1). Either case sets overflow.
- FSM states: IDLE, PREP, DIV1, DIV2, DONE.
  - IDLE: in_ready=1. On the edge where in_valid&in_ready, register all inputs and go to PREP.
  - PREP: compute det, n1 and n2 into registers.
    - det==0: set singular=1, u1=u2=0, overflow=0, go to DONE.
    - Otherwise: start the divider on |n1|<<D ÷ |det| and go to DIV1.
  - DIV1: the divider takes exactly NW cycles at one quotient bit per cycle. On done, capture saturated u1, start n2, go to DIV2.
  - DIV2: same NW cycles; capture u2, go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_valid&out_ready go to IDLE.
- Timing:
  - in_ready is 0 in every state except IDLE, so there is no overlap between consecutive operations.
  - Non-singular: out_valid rises 2·NW+2 edges after the accepting edge.
  - Singular: out_valid rises 2 edges after the accepting edge.
- Backpressure: while out_ready=0 in DONE, u1, u2, singular and overflow must not change.
- Reset, any state including mid-division:
  - Next state is IDLE.
  - out_valid=0, in_ready=1.
  - u1=u2=0, singular=0, overflow=0.
  - Divider state is cleared and any partial result is discarded.
- Boundary cases:
  - in_valid asserted outside IDLE is ignored.
  - Inputs change freely after acceptance without affecting the result.
  - A result of exactly −2^(W−1) from the negative path is not an overflow.

Decomposition:
- Shared math package (math_pkg):
  - FSM state enum typedef.
  - Saturation helper function: signed wide value → W bits plus overflow bit.
- Fixed-point widths stay in constants.h.
- Sub-module seq_divider_u (unsigned restoring divider).
  - Parameterised dividend/divisor widths.
  - Ports: start, dividend, divisor, done, quotient.
  - Synchronous active-low reset, fixed latency of NW cycles.
  - Reusable elsewhere.

Test Plan (W=32, D=16; 1.0=0x00010000):
1. Identity: a11=a22=0x10000, a12=a21=0, v=(0x30000, 0xFFFE0000) → u=(0x30000, 0xFFFE0000), singular=0, overflow=0, out_valid at accept+164 cycles.
2. 90° rotation: a11=a22=0, a12=0x10000, a21=0xFFFF0000, v=(0x18000, 0x20000) → u=(0x20000, 0xFFFE8000).
3. Diagonal scale: a11=0x20000, a22=0x8000, a12=a21=0, v=(0x10000, 0x10000) → u=(0x8000, 0x20000).
4. Singular: all aij=0x10000, any v → singular=1, u1=u2=0, out_valid 2 cycles after accept.
5. Overflow: a11=a22=0x1, a12=a21=0, v=(0x10000, 0) → u1=0x7FFFFFFF, u2=0, overflow=1.
6. Control: hold out_ready=0 for 10 cycles → outputs stable and in_ready=0. Separately, drop rst_n during DIV1 → next cycle out_valid=0 and in_ready=1. Then a fresh identity operation completes correctly.
